// File: rtl/uart_rx_sampler.sv
// UART RX oversampling front end: edge/bit counters for the RX FSM and mid-bit sampling of rx_in.
// Optional build macro UART_RX_SAMPLER_MAJ3_EN selects a 2-of-3 majority decision instead of the single mid-bit sample.
module uart_rx_sampler #(
  parameter int EDGE_W = 5,
  parameter int BIT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_in,
  input  logic [EDGE_W-1:0] prescale_in,
  input  logic              par_en_in,
  input  logic              counter_en_in,
  input  logic              data_sample_en_in,
  output logic [EDGE_W-1:0] edge_cnt_out,
  output logic [BIT_W-1:0]  bit_cnt_out,
  output logic              sampled_bit_out,
  output logic              sample_valid_out
);

  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]        samples_q, samples_d;
  logic              sampled_bit_q, sampled_bit_d;
  logic              sample_valid_q, sample_valid_d;

  logic [EDGE_W-1:0] half_s;
  logic [EDGE_W-1:0] last_edge_s;
  logic [BIT_W-1:0]  frame_end_s;
  logic              wrap_s;
  logic              sample_en_s;

`ifdef UART_RX_SAMPLER_MAJ3_EN
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
`endif

  // Frame geometry derived from the current configuration inputs.
  always_comb begin
    half_s      = prescale_in >> 1;
    last_edge_s = prescale_in - EDGE_W'(1);
    frame_end_s = par_en_in ? BIT_W'(10) : BIT_W'(9);
    wrap_s      = (edge_cnt_q >= last_edge_s);
    sample_en_s = counter_en_in & data_sample_en_in;
  end

  // Edge and bit counters; a dropped counter_en_in clears both, even on a wrap cycle.
  always_comb begin
    edge_cnt_d = '0;
    bit_cnt_d  = '0;
    if (counter_en_in) begin
      if (wrap_s) begin
        edge_cnt_d = '0;
        if (bit_cnt_q >= frame_end_s) begin
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end else begin
        edge_cnt_d = edge_cnt_q + EDGE_W'(1);
        bit_cnt_d  = bit_cnt_q;
      end
    end else begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end
  end

  // Mid-bit sampling and decision; decision is registered one cycle after edge H+1.
  always_comb begin
    samples_d      = samples_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    if (sample_en_s) begin
`ifdef UART_RX_SAMPLER_MAJ3_EN
      if ((edge_cnt_q == half_s - EDGE_W'(1)) || (edge_cnt_q == half_s) ||
          (edge_cnt_q == half_s + EDGE_W'(1))) begin
        samples_d = {samples_q[1:0], rx_in};
      end else begin
        samples_d = samples_q;
      end
      if (edge_cnt_q == half_s + EDGE_W'(1)) begin
        sampled_bit_d  = maj3({samples_q[1:0], rx_in});
        sample_valid_d = 1'b1;
      end else begin
        sampled_bit_d  = sampled_bit_q;
        sample_valid_d = 1'b0;
      end
`else
      if (edge_cnt_q == half_s) begin
        samples_d = {samples_q[1:0], rx_in};
      end else begin
        samples_d = samples_q;
      end
      if (edge_cnt_q == half_s + EDGE_W'(1)) begin
        sampled_bit_d  = samples_q[0];
        sample_valid_d = 1'b1;
      end else begin
        sampled_bit_d  = sampled_bit_q;
        sample_valid_d = 1'b0;
      end
`endif
    end else begin
      samples_d      = samples_q;
      sampled_bit_d  = sampled_bit_q;
      sample_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset to idle-line values.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      samples_q      <= 3'b111;
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
    end else begin
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      samples_q      <= samples_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign edge_cnt_out     = edge_cnt_q;
  assign bit_cnt_out      = bit_cnt_q;
  assign sampled_bit_out  = sampled_bit_q;
  assign sample_valid_out = sample_valid_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed scenarios followed by randomized traffic against a frame-level model.
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       reset, rx_in, par_en_in, counter_en_in, data_sample_en_in;
  logic [4:0] prescale_in;
  logic [4:0] edge_cnt_out;
  logic [3:0] bit_cnt_out;
  logic       sampled_bit_out, sample_valid_out;

  always #5 clk = ~clk;

  uart_rx_sampler dut (
    .clk               (clk),
    .reset             (reset),
    .rx_in             (rx_in),
    .prescale_in       (prescale_in),
    .par_en_in         (par_en_in),
    .counter_en_in     (counter_en_in),
    .data_sample_en_in (data_sample_en_in),
    .edge_cnt_out      (edge_cnt_out),
    .bit_cnt_out       (bit_cnt_out),
    .sampled_bit_out   (sampled_bit_out),
    .sample_valid_out  (sample_valid_out)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: elapsed counting cycles since the last clear, plus remembered samples.
  int   m_n = 0;
  int   m_p = 8;
  int   m_l = 9;
  logic m_samp = 1'b1;
  logic m_valid = 1'b0;
  logic m_s0 = 1'b1;
  logic m_s1 = 1'b1;

`ifdef UART_RX_SAMPLER_MAJ3_EN
  localparam bit MAJ3 = 1'b1;
`else
  localparam bit MAJ3 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int h, e;
    m_p = int'(prescale_in);
    m_l = par_en_in ? 10 : 9;
    h = m_p / 2;
    if (reset) begin
      m_n = 0; m_samp = 1'b1; m_valid = 1'b0; m_s0 = 1'b1; m_s1 = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (counter_en_in) begin
        e = m_n % m_p;
        if (data_sample_en_in) begin
          if (e == h - 1) m_s0 = rx_in;
          if (e == h) m_s1 = rx_in;
          if (e == h + 1) begin
            if (MAJ3) m_samp = ((int'(m_s0) + int'(m_s1) + int'(rx_in)) >= 2);
            else m_samp = m_s1;
            m_valid = 1'b1;
          end
        end
        m_n++;
      end else begin
        m_n = 0;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("edge_cnt", edge_cnt_out, m_n % m_p);
    check("bit_cnt", bit_cnt_out, (m_n / m_p) % (m_l + 1));
    check("sampled_bit", sampled_bit_out, m_samp);
    check("sample_valid", sample_valid_out, m_valid);
  endtask

  task automatic clear_counters();
    counter_en_in = 1'b0;
    cycle();
    counter_en_in = 1'b1;
  endtask

  initial begin
    logic [10:0] frame_bits;
    int   max_bit;
    bit   pulsed;
    logic base;

    reset = 1'b1; rx_in = 1'b1; prescale_in = 5'd8; par_en_in = 1'b0;
    counter_en_in = 1'b0; data_sample_en_in = 1'b0;
    cycle();
    cycle();
    check("reset_edge", edge_cnt_out, 0);
    check("reset_bit", bit_cnt_out, 0);
    check("reset_sampled", sampled_bit_out, 1);
    check("reset_valid", sample_valid_out, 0);
    reset = 1'b0;

    // P=8, no parity, idle line: bit counter runs 0..9 and wraps at the 10th wrap.
    clear_counters();
    data_sample_en_in = 1'b1;
    max_bit = 0;
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (int'(bit_cnt_out) > max_bit) max_bit = int'(bit_cnt_out);
    end
    check("p8_max_bit", max_bit, 9);
    check("p8_wrap_bit", bit_cnt_out, 0);

    // P=16 with parity, frame 0x5A: start, data LSB first, even parity, stop.
    prescale_in = 5'd16; par_en_in = 1'b1;
    clear_counters();
    frame_bits = 11'b10_0101_1010_0;
    max_bit = 0;
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < 16; c++) begin
        rx_in = frame_bits[b];
        cycle();
        if (int'(bit_cnt_out) > max_bit) max_bit = int'(bit_cnt_out);
        if (c == 9) begin
          check("frame_edge10", edge_cnt_out, 10);
          check("frame_bit", sampled_bit_out, frame_bits[b]);
        end
      end
    end
    check("p16_max_bit", max_bit, 10);

    // Single-cycle glitch at the mid-bit sample edge, P=8.
    prescale_in = 5'd8; par_en_in = 1'b0;
    clear_counters();
    for (int c = 0; c < 8; c++) begin rx_in = 1'b0; cycle(); end
    check("glitch_pre", sampled_bit_out, 0);
    for (int c = 0; c < 8; c++) begin
      rx_in = (c == 4) ? 1'b0 : 1'b1;
      cycle();
      if (c == 5) check("glitch_low", sampled_bit_out, MAJ3 ? 1 : 0);
    end
    for (int c = 0; c < 8; c++) begin
      rx_in = (c == 4) ? 1'b1 : 1'b0;
      cycle();
      if (c == 5) check("glitch_high", sampled_bit_out, MAJ3 ? 0 : 1);
    end

    // counter_en falls at edge 5 of bit 3, which is also the decision edge.
    clear_counters();
    rx_in = 1'b1;
    for (int i = 0; i < 29; i++) cycle();
    check("drop_pre_edge", edge_cnt_out, 5);
    check("drop_pre_bit", bit_cnt_out, 3);
    counter_en_in = 1'b0;
    cycle();
    check("drop_edge", edge_cnt_out, 0);
    check("drop_bit", bit_cnt_out, 0);
    check("drop_valid", sample_valid_out, 0);

    // Mid-frame reset at bit 6, edge 4.
    counter_en_in = 1'b1; rx_in = 1'b0;
    for (int i = 0; i < 52; i++) cycle();
    check("rst_pre_edge", edge_cnt_out, 4);
    check("rst_pre_bit", bit_cnt_out, 6);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("midrst_edge", edge_cnt_out, 0);
    check("midrst_bit", bit_cnt_out, 0);
    check("midrst_sampled", sampled_bit_out, 1);
    check("midrst_valid", sample_valid_out, 0);

    // Sampling disabled for a whole bit with the line low.
    counter_en_in = 1'b1; data_sample_en_in = 1'b0; rx_in = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (sample_valid_out) pulsed = 1'b1;
    end
    check("nosample_pulse", pulsed, 0);
    check("nosample_hold", sampled_bit_out, 1);
    check("nosample_bit", bit_cnt_out, 1);

    // Randomized traffic: config changes only while counters are stopped, sample enable per bit.
    base = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (!counter_en_in) begin
        prescale_in = ($urandom_range(0, 1) == 0) ? 5'd8 : 5'd16;
        par_en_in = 1'($urandom_range(0, 1));
        data_sample_en_in = ($urandom_range(0, 3) != 0);
        counter_en_in = ($urandom_range(0, 2) == 0);
      end else if ($urandom_range(0, 63) == 0) begin
        counter_en_in = 1'b0;
      end else if (m_n % m_p == 0) begin
        base = 1'($urandom_range(0, 1));
        data_sample_en_in = ($urandom_range(0, 3) != 0);
      end
      rx_in = base ^ ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
